// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: datum selects, FSM states
// and the pending-write queue entry.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_SP   = 2'b11
  } wb_sel_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SAVE = 1'b1
  } wb_state_t;

  localparam logic [4:0] ILR_REG = 5'd31;
  localparam logic [4:0] LR_REG  = 5'd30;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of displaced register writes; exposes every slot and
// its valid bit so the owner can run hazard compares against the whole queue.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output wb_entry_t                  entries [DEPTH],
  output logic [DEPTH-1:0]           vld,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: storage is deliberately not reset; the valid bits alone decide which
  // slots hold live data, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (pop) begin
        rd_ptr      <= bump(rd_ptr);
        vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr      <= bump(wr_ptr);
        vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/reg_writeback.sv
// Owns the register-file write port: arbitrates interrupt ILR saves, queued
// writes and direct pipeline writes, and drives the SP update path to decode.
module reg_writeback #(
  parameter int         DEPTH   = 2,
  parameter logic [4:0] ILR_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_wEn,
  input  logic [4:0]  in_reg,
  input  logic [1:0]  in_sel,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] link_pc,
  input  logic        in_SPwe,
  input  logic [31:0] in_sp,
  input  logic        irq_req,
  input  logic [31:0] irq_pc,
  input  logic [4:0]  q0_reg,
  input  logic [4:0]  q1_reg,
  output logic        wEn,
  output logic [4:0]  wReg,
  output logic [31:0] wData,
  output logic        SPwe_o,
  output logic [31:0] SPin,
  output logic        stall,
  output logic        irq_busy,
  output logic        irq_done,
  output logic        q0_hit,
  output logic        q1_hit
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_pkg::wb_state_t state;
  wb_pkg::wb_sel_t   sel;
  wb_pkg::wb_entry_t head;
  wb_pkg::wb_entry_t entries [DEPTH];
  wb_pkg::wb_entry_t push_entry;
  logic [DEPTH-1:0]  vld;
  logic [CW-1:0]     count;
  logic [31:0]       ilr_q;
  logic [31:0]       datum;
  logic              live;
  logic              accepted;
  logic              push;
  logic              pop;
  logic              saving;

  assign live     = ~rst;
  assign sel      = wb_pkg::wb_sel_t'(in_sel);
  assign stall    = (count == CW'(DEPTH));
  assign accepted = live & in_valid & in_wEn & ~stall;
  assign saving   = (state == wb_pkg::WB_SAVE);

  // Outputs are forced low while reset is held, even with a live upstream.
  assign SPwe_o = live & in_valid & in_SPwe & ~stall;
  assign SPin   = live ? in_sp : 32'd0;

  always_comb begin
    datum = alu_res;
    case (sel)
      wb_pkg::WB_ALU:  datum = alu_res;
      wb_pkg::WB_MEM:  datum = mem_rdata;
      wb_pkg::WB_LINK: datum = link_pc;
      wb_pkg::WB_SP:   datum = in_sp;
      default:         datum = alu_res;
    endcase
  end

  assign push_entry = '{rd: in_reg, data: datum};

  // Once anything is queued, new writes must queue behind it to keep order.
  always_comb begin
    wEn   = 1'b0;
    wReg  = 5'd0;
    wData = 32'd0;
    push  = 1'b0;
    pop   = 1'b0;
    if (saving) begin
      wEn   = 1'b1;
      wReg  = ILR_REG;
      wData = ilr_q;
      push  = accepted;
    end else if (count != '0) begin
      wEn   = 1'b1;
      wReg  = head.rd;
      wData = head.data;
      pop   = 1'b1;
      push  = accepted;
    end else if (accepted) begin
      wEn   = 1'b1;
      wReg  = in_reg;
      wData = datum;
    end
  end

  always_comb begin
    q0_hit = (push && in_reg == q0_reg) || (saving && q0_reg == ILR_REG);
    q1_hit = (push && in_reg == q1_reg) || (saving && q1_reg == ILR_REG);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && entries[i].rd == q0_reg) q0_hit = 1'b1;
      if (vld[i] && entries[i].rd == q1_reg) q1_hit = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= wb_pkg::WB_IDLE;
      ilr_q    <= 32'd0;
      irq_busy <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      case (state)
        wb_pkg::WB_IDLE: begin
          if (irq_req) begin
            ilr_q    <= irq_pc;
            state    <= wb_pkg::WB_SAVE;
            irq_busy <= 1'b1;
            irq_done <= 1'b1;
          end
        end
        wb_pkg::WB_SAVE: begin
          state    <= wb_pkg::WB_IDLE;
          irq_busy <= 1'b0;
          irq_done <= 1'b0;
        end
        default: state <= wb_pkg::WB_IDLE;
      endcase
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .vld        (vld),
    .count      (count)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: stimulus pushes the expected write-port
// sequence, a negedge monitor pops and compares every register-file write.
module tb_reg_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk, rst;
  logic        in_valid, in_wEn, in_SPwe, irq_req;
  logic [4:0]  in_reg, q0_reg, q1_reg;
  logic [1:0]  in_sel;
  logic [31:0] alu_res, mem_rdata, link_pc, in_sp, irq_pc;
  logic        wEn, SPwe_o, stall, irq_busy, irq_done, q0_hit, q1_hit;
  logic [4:0]  wReg;
  logic [31:0] wData, SPin;

  reg_writeback #(.DEPTH(DEPTH), .ILR_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wEn(in_wEn), .in_reg(in_reg),
    .in_sel(in_sel), .alu_res(alu_res), .mem_rdata(mem_rdata), .link_pc(link_pc),
    .in_SPwe(in_SPwe), .in_sp(in_sp), .irq_req(irq_req), .irq_pc(irq_pc),
    .q0_reg(q0_reg), .q1_reg(q1_reg), .wEn(wEn), .wReg(wReg), .wData(wData),
    .SPwe_o(SPwe_o), .SPin(SPin), .stall(stall), .irq_busy(irq_busy),
    .irq_done(irq_done), .q0_hit(q0_hit), .q1_hit(q1_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input logic irq);
    sb.push_back('{rd: r, data: d, irq: irq});
  endtask

  // Monitor: every write must be the next expected one, with irq flags matching.
  always @(negedge clk) begin
    if (!rst) begin
      if (wEn) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {27'd0, wReg, wData}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_write", {25'd0, irq_busy, irq_done, wReg, wData},
                {25'd0, mon_e.irq, mon_e.irq, mon_e.rd, mon_e.data});
        end
      end else begin
        check("idle_no_irq_done", {62'd0, irq_busy, irq_done}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid  = 1'b0;
    in_wEn    = 1'b0;
    in_reg    = 5'd0;
    in_sel    = 2'b00;
    alu_res   = 32'hA5A5_0000;
    mem_rdata = 32'h5A5A_0000;
    link_pc   = 32'hC3C3_0000;
    in_SPwe   = 1'b0;
    in_sp     = 32'h0;
    irq_req   = 1'b0;
    irq_pc    = 32'h0;
    q0_reg    = 5'd0;
    q1_reg    = 5'd0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [1:0] s, input logic [31:0] d);
    in_valid = 1'b1;
    in_wEn   = 1'b1;
    in_reg   = r;
    in_sel   = s;
    case (s)
      2'b00:   alu_res   = d;
      2'b01:   mem_rdata = d;
      2'b10:   link_pc   = d;
      default: in_sp     = d;
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {57'd0, wEn, SPwe_o, stall, irq_busy, irq_done, q0_hit, q1_hit}, 64'd0);
    check({tag, "_wr"}, {27'd0, wReg, wData}, 64'd0);
    check({tag, "_spin"}, {32'd0, SPin}, 64'd0);
  endtask

  bit stall_tab [12] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  bit irq_tab   [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    int n;
    clear_in();
    rst = 1'b1;
    // Active upstream during reset must not leak to the outputs.
    wr(5'd5, 2'b00, 32'h77);
    in_SPwe = 1'b1;
    in_sp   = 32'h99;
    q0_reg  = 5'd5;
    q1_reg  = 5'd31;
    #12;
    check_zero("reset");
    step();
    rst = 1'b0;
    clear_in();

    // Direct write, zero latency.
    step(); clear_in();
    wr(5'd5, 2'b00, 32'h1234);
    q0_reg = 5'd5;
    expect_wr(5'd5, 32'h1234, 1'b0);
    @(negedge clk);
    check("direct_stall", {63'd0, stall}, 64'd0);
    check("direct_no_hazard", {63'd0, q0_hit}, 64'd0);

    // Interrupt save with no pipeline traffic; SP path live during SAVE.
    step(); clear_in();
    irq_req = 1'b1;
    irq_pc  = 32'h40;
    expect_wr(5'd31, 32'h40, 1'b1);
    step(); clear_in();
    in_valid = 1'b1;
    in_SPwe  = 1'b1;
    in_sp    = 32'h2FFC;
    @(negedge clk);
    check("save_spwe", {63'd0, SPwe_o}, 64'd1);
    check("save_spin", {32'd0, SPin}, 64'h2FFC);
    step(); clear_in();

    // irq with r3 in N, r7 in N+1: r3, r31, r7 order and hazards.
    step(); clear_in();
    irq_req = 1'b1;
    irq_pc  = 32'h80;
    wr(5'd3, 2'b00, 32'h11);
    q0_reg = 5'd3;
    q1_reg = 5'd31;
    expect_wr(5'd3, 32'h11, 1'b0);
    expect_wr(5'd31, 32'h80, 1'b1);
    expect_wr(5'd7, 32'h22, 1'b0);
    @(negedge clk);
    check("n_q0_hit_r3", {63'd0, q0_hit}, 64'd0);
    check("n_q1_hit_ilr", {63'd0, q1_hit}, 64'd0);
    step(); clear_in();
    wr(5'd7, 2'b01, 32'h22);
    q0_reg = 5'd7;
    q1_reg = 5'd31;
    @(negedge clk);
    check("n1_q0_hit_r7", {63'd0, q0_hit}, 64'd1);
    check("n1_q1_hit_ilr", {63'd0, q1_hit}, 64'd1);
    step(); clear_in();
    step(); clear_in();

    // Continuous writes with irq every other cycle until the queue fills.
    expect_wr(5'd1, 32'h101, 1'b0);
    expect_wr(5'd31, 32'h300, 1'b1);
    expect_wr(5'd2, 32'h102, 1'b0);
    expect_wr(5'd31, 32'h302, 1'b1);
    expect_wr(5'd3, 32'h103, 1'b0);
    expect_wr(5'd31, 32'h304, 1'b1);
    expect_wr(5'd4, 32'h104, 1'b0);
    expect_wr(5'd31, 32'h306, 1'b1);
    expect_wr(5'd5, 32'h105, 1'b0);
    expect_wr(5'd6, 32'h106, 1'b0);
    expect_wr(5'd7, 32'h107, 1'b0);
    expect_wr(5'd8, 32'h108, 1'b0);
    n = 1;
    for (int k = 0; k < 12; k++) begin
      step(); clear_in();
      irq_req = irq_tab[k];
      irq_pc  = 32'h300 + k;
      if (n <= 8) begin
        wr(5'(n), 2'b00, 32'h100 + n);
        in_SPwe = 1'b1;
        in_sp   = 32'h2000 + k;
      end
      q0_reg = 5'(n);
      q1_reg = 5'd4;
      @(negedge clk);
      check($sformatf("stall_k%0d", k), {63'd0, stall}, {63'd0, stall_tab[k]});
      check($sformatf("spwe_k%0d", k), {63'd0, SPwe_o}, {63'd0, (n <= 8) && !stall_tab[k]});
      if (k == 4) begin
        check("stalled_input_no_hit", {63'd0, q0_hit}, 64'd0);
        check("queued_r4_hit", {63'd0, q1_hit}, 64'd1);
      end
      if (!stall_tab[k]) n++;
    end
    step(); clear_in();

    // Fill the queue with r7, r9, then reset: neither may ever be written.
    expect_wr(5'd1, 32'h501, 1'b0);
    expect_wr(5'd31, 32'h200, 1'b1);
    expect_wr(5'd2, 32'h502, 1'b0);
    expect_wr(5'd31, 32'h204, 1'b1);
    step(); clear_in();
    irq_req = 1'b1; irq_pc = 32'h200; wr(5'd1, 2'b00, 32'h501);
    step(); clear_in();
    wr(5'd2, 2'b00, 32'h502);
    step(); clear_in();
    irq_req = 1'b1; irq_pc = 32'h204; wr(5'd7, 2'b00, 32'h507);
    step(); clear_in();
    wr(5'd9, 2'b00, 32'h509);
    step(); clear_in();
    wr(5'd11, 2'b00, 32'h5FF);
    in_SPwe = 1'b1;
    in_sp   = 32'h1234;
    q0_reg  = 5'd7;
    q1_reg  = 5'd9;
    rst     = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    check_zero("midrst_hold");
    step();
    rst = 1'b0;
    clear_in();
    q0_reg = 5'd7;
    q1_reg = 5'd9;
    @(negedge clk);
    check("post_rst_hits", {62'd0, q0_hit, q1_hit}, 64'd0);
    repeat (3) begin
      step(); clear_in();
    end

    // Remaining datum selects after reset.
    expect_wr(5'd12, 32'h612, 1'b0);
    expect_wr(5'd13, 32'h713, 1'b0);
    step(); clear_in();
    wr(5'd12, 2'b10, 32'h612);
    step(); clear_in();
    wr(5'd13, 2'b11, 32'h713);
    repeat (3) begin
      step(); clear_in();
    end
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
